// File: rtl/iob_pcie_tx_arb_if.sv
// -----------------------------------------------------------------------------
// iob_pcie_tx_arb_if
// Bundles the two requester ports and the RIFFA-style CHNL_TX channel port of
// the two-requester PCIe TX arbiter.
//
//   slave  : arbiter view (inputs from requesters/channel, drives acks/channel)
//   master : environment view (requesters plus the channel core)
//
// Per requester N (0/1):
//   reqN_valid/len/off/last   transaction request, held until reqN_ack
//   reqN_ack                  1-cycle pulse, parameters captured
//   reqN_data/data_valid      data word offered by the requester
//   reqN_data_ren             word consumed this cycle
//   reqN_done                 1-cycle pulse, transaction finished
// Channel:
//   CHNL_TX/ACK/LAST/LEN/OFF  transaction handshake and captured parameters
//   CHNL_TX_DATA/DATA_VALID   muxed data of the granted requester
//   CHNL_TX_DATA_REN          channel consumes a word
// -----------------------------------------------------------------------------
interface iob_pcie_tx_arb_if #(
    parameter int DATA_W = 32
);
    logic              req0_valid;
    logic [31:0]       req0_len;
    logic [30:0]       req0_off;
    logic              req0_last;
    logic              req0_ack;
    logic [DATA_W-1:0] req0_data;
    logic              req0_data_valid;
    logic              req0_data_ren;
    logic              req0_done;

    logic              req1_valid;
    logic [31:0]       req1_len;
    logic [30:0]       req1_off;
    logic              req1_last;
    logic              req1_ack;
    logic [DATA_W-1:0] req1_data;
    logic              req1_data_valid;
    logic              req1_data_ren;
    logic              req1_done;

    logic              CHNL_TX;
    logic              CHNL_TX_ACK;
    logic              CHNL_TX_LAST;
    logic [31:0]       CHNL_TX_LEN;
    logic [30:0]       CHNL_TX_OFF;
    logic [DATA_W-1:0] CHNL_TX_DATA;
    logic              CHNL_TX_DATA_VALID;
    logic              CHNL_TX_DATA_REN;

    modport slave (
        input  req0_valid, req0_len, req0_off, req0_last, req0_data, req0_data_valid,
        output req0_ack, req0_data_ren, req0_done,
        input  req1_valid, req1_len, req1_off, req1_last, req1_data, req1_data_valid,
        output req1_ack, req1_data_ren, req1_done,
        output CHNL_TX, CHNL_TX_LAST, CHNL_TX_LEN, CHNL_TX_OFF,
        output CHNL_TX_DATA, CHNL_TX_DATA_VALID,
        input  CHNL_TX_ACK, CHNL_TX_DATA_REN
    );

    modport master (
        output req0_valid, req0_len, req0_off, req0_last, req0_data, req0_data_valid,
        input  req0_ack, req0_data_ren, req0_done,
        output req1_valid, req1_len, req1_off, req1_last, req1_data, req1_data_valid,
        input  req1_ack, req1_data_ren, req1_done,
        input  CHNL_TX, CHNL_TX_LAST, CHNL_TX_LEN, CHNL_TX_OFF,
        input  CHNL_TX_DATA, CHNL_TX_DATA_VALID,
        output CHNL_TX_ACK, CHNL_TX_DATA_REN
    );
endinterface

// File: rtl/iob_pcie_tx_arb.sv
// -----------------------------------------------------------------------------
// iob_pcie_tx_arb
// Shares one RIFFA-style PCIe TX channel between two requesters. Requests are
// arbitrated round-robin, the CHNL_TX/CHNL_TX_ACK handshake is run, exactly
// LEN 32-bit words are streamed from the granted requester and the channel is
// released. Every transaction costs IDLE + REQ + DONE plus its data beats.
//
// Ports:
//   clk    system clock
//   rst    asynchronous active-high reset
//   bus    iob_pcie_tx_arb_if.slave (requester 0/1 ports and CHNL_TX port)
//   busy   FSM not in IDLE
//   grant  index of the current/last granted requester (1 after reset, so
//          requester 0 wins the first tie)
//   err    1-cycle pulse when CHNL_TX_ACK times out
//
// Optional feature: define IOB_PCIE_TX_ARB_TIMEOUT_EN to abort a REQ phase
// after TIMEOUT cycles without CHNL_TX_ACK. Without it REQ waits indefinitely
// and err is tied to 0.
// -----------------------------------------------------------------------------
module iob_pcie_tx_arb #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    iob_pcie_tx_arb_if.slave bus,
    output logic             busy,
    output logic             grant,
    output logic             err
);

    // RIFFA channels are fixed at 32 bits and the timeout needs at least one cycle.
    if (DATA_W != 32 || TIMEOUT < 1) begin : g_param_check
        $error("iob_pcie_tx_arb: DATA_W must be 32 and TIMEOUT must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        grant_q, grant_d;
    logic [31:0] len_q, len_d;
    logic [30:0] off_q, off_d;
    logic        last_q, last_d;
    logic [31:0] cnt_q, cnt_d;
    logic [1:0]  ack_q, ack_d;

    logic              winner;
    logic              chnl_tx;
    logic [DATA_W-1:0] data_mux;
    logic              dvalid_mux;
    logic              ren0, ren1;
    logic              done0, done1;
    logic              beat;
    logic              err_c;

`ifdef IOB_PCIE_TX_ARB_TIMEOUT_EN
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);
    logic [31:0] to_cnt_q, to_cnt_d;
    logic        to_expire;
    assign to_expire = (to_cnt_q == TO_LAST);
`endif

    // Round-robin: on a tie the requester that was not granted last time wins.
    assign winner = (bus.req0_valid && bus.req1_valid) ? ~grant_q : bus.req1_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= 1'b1;
            len_q    <= '0;
            off_q    <= '0;
            last_q   <= 1'b0;
            cnt_q    <= '0;
            ack_q    <= 2'b00;
`ifdef IOB_PCIE_TX_ARB_TIMEOUT_EN
            to_cnt_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            len_q    <= len_d;
            off_q    <= off_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            ack_q    <= ack_d;
`ifdef IOB_PCIE_TX_ARB_TIMEOUT_EN
            to_cnt_q <= to_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        len_d      = len_q;
        off_d      = off_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        ack_d      = 2'b00;
        chnl_tx    = 1'b0;
        data_mux   = '0;
        dvalid_mux = 1'b0;
        ren0       = 1'b0;
        ren1       = 1'b0;
        done0      = 1'b0;
        done1      = 1'b0;
        beat       = 1'b0;
        err_c      = 1'b0;
`ifdef IOB_PCIE_TX_ARB_TIMEOUT_EN
        to_cnt_d   = '0;
`endif

        case (state_q)
            IDLE: begin
                if (bus.req0_valid || bus.req1_valid) begin
                    // Parameters are frozen here; the registered ack marks
                    // the first REQ cycle.
                    grant_d = winner;
                    len_d   = winner ? bus.req1_len  : bus.req0_len;
                    off_d   = winner ? bus.req1_off  : bus.req0_off;
                    last_d  = winner ? bus.req1_last : bus.req0_last;
                    ack_d   = winner ? 2'b10 : 2'b01;
                    state_d = REQ;
                end
            end

            REQ: begin
                chnl_tx = 1'b1;
`ifdef IOB_PCIE_TX_ARB_TIMEOUT_EN
                to_cnt_d = to_cnt_q + 32'd1;
`endif
                if (bus.CHNL_TX_ACK) begin
                    cnt_d   = '0;
                    state_d = (len_q == 32'd0) ? DONE : DATA;
                end
`ifdef IOB_PCIE_TX_ARB_TIMEOUT_EN
                // An ACK arriving on the expiry cycle takes priority.
                else if (to_expire) begin
                    err_c   = 1'b1;
                    state_d = DONE;
                end
`endif
            end

            DATA: begin
                chnl_tx    = 1'b1;
                data_mux   = grant_q ? bus.req1_data : bus.req0_data;
                dvalid_mux = grant_q ? bus.req1_data_valid : bus.req0_data_valid;
                ren0       = ~grant_q & bus.CHNL_TX_DATA_REN;
                ren1       =  grant_q & bus.CHNL_TX_DATA_REN;
                beat       = dvalid_mux & bus.CHNL_TX_DATA_REN;
                if (beat) begin
                    cnt_d = cnt_q + 32'd1;
                    if (cnt_q == len_q - 32'd1) begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                done0   = ~grant_q;
                done1   =  grant_q;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    assign bus.req0_ack           = ack_q[0];
    assign bus.req1_ack           = ack_q[1];
    assign bus.req0_data_ren      = ren0;
    assign bus.req1_data_ren      = ren1;
    assign bus.req0_done          = done0;
    assign bus.req1_done          = done1;
    assign bus.CHNL_TX            = chnl_tx;
    assign bus.CHNL_TX_LAST       = last_q;
    assign bus.CHNL_TX_LEN        = len_q;
    assign bus.CHNL_TX_OFF        = off_q;
    assign bus.CHNL_TX_DATA       = data_mux;
    assign bus.CHNL_TX_DATA_VALID = dvalid_mux;

    assign busy  = (state_q != IDLE);
    assign grant = grant_q;
    assign err   = err_c;

endmodule

// File: tb/tb_iob_pcie_tx_arb.sv
module tb_iob_pcie_tx_arb;

    logic clk = 1'b0;
    logic rst;
    logic busy, grant, err;

    always #5 clk = ~clk;

    iob_pcie_tx_arb_if #(.DATA_W(32)) bus ();

    iob_pcie_tx_arb #(.DATA_W(32), .TIMEOUT(16)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy),
        .grant(grant),
        .err  (err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Scoreboard entries: {requester id, data word}, in expected channel order.
    logic [32:0] exp_q[$];
    logic [31:0] src0[$];
    logic [31:0] src1[$];

    // Requester/channel model state.
    int rem0 = 0, rem1 = 0;
    int ack_delay = 0;
    int ack_wait  = 0;
    bit ack_en = 1'b1;
    bit acked  = 1'b0;
    bit stall  = 1'b0;

    // Monitor observations.
    int n_ack0 = 0, n_ack1 = 0, n_done0 = 0, n_done1 = 0;
    int n_beats = 0, n_tx = 0, n_err = 0, cyc = 0;
    int last_tx_cyc = 0, done_cyc = 0, ack_cyc = 0, err_cyc = 0;
    logic [31:0] ack_len;
    logic [30:0] ack_off;
    logic        ack_last;
    bit ren0_seen = 1'b0, dv_seen = 1'b0;
    int glog[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (bus.CHNL_TX) begin
            n_tx++;
            last_tx_cyc = cyc;
        end
        if (bus.req0_ack || bus.req1_ack) begin
            glog.push_back(bus.req1_ack ? 1 : 0);
            ack_cyc  = cyc;
            ack_len  = bus.CHNL_TX_LEN;
            ack_off  = bus.CHNL_TX_OFF;
            ack_last = bus.CHNL_TX_LAST;
        end
        if (bus.req0_ack) n_ack0++;
        if (bus.req1_ack) n_ack1++;
        if (bus.req0_done) begin n_done0++; done_cyc = cyc; end
        if (bus.req1_done) begin n_done1++; done_cyc = cyc; end
        if (err) begin n_err++; err_cyc = cyc; end
        if (bus.req0_data_ren) ren0_seen = 1'b1;
        if (bus.CHNL_TX_DATA_VALID) dv_seen = 1'b1;
        if (bus.CHNL_TX_DATA_VALID && bus.CHNL_TX_DATA_REN) begin
            n_beats++;
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_beat", {31'd0, grant, bus.CHNL_TX_DATA}, 64'h1_FFFF_FFFF);
            end else begin
                chk("sb_beat", {31'd0, grant, bus.CHNL_TX_DATA}, {31'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic add0(input logic [31:0] w);
        src0.push_back(w);
        exp_q.push_back({1'b0, w});
    endtask

    task automatic add1(input logic [31:0] w);
        src1.push_back(w);
        exp_q.push_back({1'b1, w});
    endtask

    // Drives all requester/channel inputs for the coming cycle.
    task automatic drive();
        bit g0, g1;
        g0 = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        g1 = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.req0_valid = (rem0 > 0);
        bus.req1_valid = (rem1 > 0);
        // Scramble parameters once a request is accepted; the DUT must not care.
        if (rem0 == 0) bus.req0_len = 32'hFF;
        if (rem1 == 0) bus.req1_len = 32'hFF;
        if (src0.size() > 0) bus.req0_data = src0[0];
        else                 bus.req0_data = '0;
        if (src1.size() > 0) bus.req1_data = src1[0];
        else                 bus.req1_data = '0;
        bus.req0_data_valid  = (src0.size() > 0) && g0;
        bus.req1_data_valid  = (src1.size() > 0) && g1;
        bus.CHNL_TX_DATA_REN = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        if (bus.CHNL_TX && !acked && ack_en) begin
            if (ack_wait >= ack_delay) begin
                bus.CHNL_TX_ACK = 1'b1;
                acked = 1'b1;
            end else begin
                ack_wait++;
                bus.CHNL_TX_ACK = 1'b0;
            end
        end else begin
            bus.CHNL_TX_ACK = 1'b0;
        end
        if (!bus.CHNL_TX) begin
            acked    = 1'b0;
            ack_wait = 0;
        end
    endtask

    task automatic cycle();
        bit t0, t1, a0, a1;
        @(negedge clk);
        t0 = bus.req0_data_valid && bus.req0_data_ren;
        t1 = bus.req1_data_valid && bus.req1_data_ren;
        a0 = bus.req0_ack;
        a1 = bus.req1_ack;
        @(posedge clk);
        #1;
        if (t0) void'(src0.pop_front());
        if (t1) void'(src1.pop_front());
        if (a0 && rem0 > 0) rem0--;
        if (a1 && rem1 > 0) rem1--;
        drive();
    endtask

    task automatic wait_dones(input int tgt, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (n_done0 + n_done1 >= tgt) break;
            cycle();
        end
        chk(tag, 64'(n_done0 + n_done1 >= tgt), 64'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rem0 = 0; rem1 = 0;
        src0.delete(); src1.delete();
        acked = 1'b0; ack_wait = 0; stall = 1'b0; ack_en = 1'b1;
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        drive();
    endtask

    int b_ack0, b_done0, b_done1, b_beats, b_tx, b_err;

    initial begin
        rst = 1'b1;
        bus.req0_len = '0; bus.req0_off = '0; bus.req0_last = 1'b0;
        bus.req1_len = '0; bus.req1_off = '0; bus.req1_last = 1'b0;
        bus.CHNL_TX_ACK = 1'b0;
        drive();
        #2;
        // Reset state
        chk("rst_busy",   64'(busy), 64'd0);
        chk("rst_grant",  64'(grant), 64'd1);
        chk("rst_tx",     64'(bus.CHNL_TX), 64'd0);
        chk("rst_len",    64'(bus.CHNL_TX_LEN), 64'd0);
        chk("rst_dvalid", 64'(bus.CHNL_TX_DATA_VALID), 64'd0);
        chk("rst_acks",   64'({bus.req1_ack, bus.req0_ack}), 64'd0);
        chk("rst_err",    64'(err), 64'd0);
        do_reset();

        // Single transfer: req0 len=4, ACK after 2 cycles
        b_ack0 = n_ack0; b_done0 = n_done0; b_beats = n_beats; b_tx = n_tx;
        bus.req0_len = 32'd4; bus.req0_off = 31'd0; bus.req0_last = 1'b1;
        for (int i = 0; i < 4; i++) add0(32'hA0 + 32'(i));
        ack_delay = 2;
        rem0 = 1;
        drive();
        wait_dones(1, 60, "t1_timeout");
        chk("t1_ack_pulses",  64'(n_ack0 - b_ack0), 64'd1);
        chk("t1_done_pulses", 64'(n_done0 - b_done0), 64'd1);
        chk("t1_beats",       64'(n_beats - b_beats), 64'd4);
        chk("t1_len",         64'(ack_len), 64'd4);
        chk("t1_last_off",    {31'd0, ack_last, 1'b0, ack_off}, {31'd0, 1'b1, 32'd0});
        chk("t1_tx_cycles",   64'(n_tx - b_tx), 64'd7);
        chk("t1_tx_drop",     64'(done_cyc - last_tx_cyc), 64'd1);

        // Both requesters valid after reset, len=2, held
        do_reset();
        glog.delete();
        b_done0 = n_done0; b_done1 = n_done1;
        bus.req0_len = 32'd2; bus.req1_len = 32'd2;
        bus.req1_off = 31'h123; bus.req1_last = 1'b0;
        add0(32'hB0); add0(32'hB1);
        add1(32'hC0); add1(32'hC1);
        add0(32'hB2); add0(32'hB3);
        ack_delay = 0;
        rem0 = 2; rem1 = 1;
        drive();
        wait_dones(n_done0 + n_done1 + 3, 100, "t2_timeout");
        chk("t2_grants", 64'(glog.size() == 3 ? (glog[0] * 4 + glog[1] * 2 + glog[2]) : 99), 64'd2);
        chk("t2_done0",  64'(n_done0 - b_done0), 64'd2);
        chk("t2_done1",  64'(n_done1 - b_done1), 64'd1);

        // Stall: req1 len=3, random data_valid/ren
        b_beats = n_beats; b_done1 = n_done1;
        ren0_seen = 1'b0;
        bus.req1_len = 32'd3; bus.req1_off = 31'h7654321; bus.req1_last = 1'b0;
        add1(32'hD0); add1(32'hD1); add1(32'hD2);
        stall = 1'b1;
        rem1 = 1;
        drive();
        wait_dones(n_done0 + n_done1 + 1, 300, "t3_timeout");
        stall = 1'b0;
        chk("t3_beats",     64'(n_beats - b_beats), 64'd3);
        chk("t3_ren0_idle", 64'(ren0_seen), 64'd0);
        chk("t3_done1",     64'(n_done1 - b_done1), 64'd1);
        chk("t3_off",       64'(ack_off), 64'h7654321);
        chk("t3_grant",     64'(grant), 64'd1);

        // len=0 on req0
        b_beats = n_beats; b_done0 = n_done0; b_tx = n_tx;
        dv_seen = 1'b0;
        bus.req0_len = 32'd0; bus.req0_last = 1'b1;
        ack_delay = 1;
        rem0 = 1;
        drive();
        wait_dones(n_done0 + n_done1 + 1, 40, "t4_timeout");
        chk("t4_beats",     64'(n_beats - b_beats), 64'd0);
        chk("t4_no_dvalid", 64'(dv_seen), 64'd0);
        chk("t4_done0",     64'(n_done0 - b_done0), 64'd1);
        chk("t4_tx_cycles", 64'(n_tx - b_tx), 64'd2);
        chk("t4_done_lat",  64'(done_cyc - last_tx_cyc), 64'd1);

        // Reset during DATA after 5 of 8 words
        b_beats = n_beats; b_done0 = n_done0;
        bus.req0_len = 32'd8;
        for (int i = 0; i < 8; i++) add0(32'hE0 + 32'(i));
        ack_delay = 0;
        rem0 = 1;
        drive();
        for (int i = 0; i < 60; i++) begin
            if (n_beats - b_beats >= 5) break;
            cycle();
        end
        chk("t5_five_beats", 64'(n_beats - b_beats), 64'd5);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_async_tx",     64'(bus.CHNL_TX), 64'd0);
        chk("t5_async_busy",   64'(busy), 64'd0);
        chk("t5_async_dvalid", 64'(bus.CHNL_TX_DATA_VALID), 64'd0);
        chk("t5_async_ren",    64'({bus.req1_data_ren, bus.req0_data_ren}), 64'd0);
        chk("t5_async_len",    64'(bus.CHNL_TX_LEN), 64'd0);
        chk("t5_async_data",   64'(bus.CHNL_TX_DATA), 64'd0);
        exp_q.delete();
        do_reset();
        chk("t5_no_done",   64'(n_done0 - b_done0), 64'd0);
        chk("t5_grant_rst", 64'(grant), 64'd1);
        b_beats = n_beats; b_done1 = n_done1;
        bus.req1_len = 32'd1;
        add1(32'hF0);
        rem1 = 1;
        drive();
        wait_dones(n_done0 + n_done1 + 1, 40, "t5_timeout");
        chk("t5_beats", 64'(n_beats - b_beats), 64'd1);
        chk("t5_done1", 64'(n_done1 - b_done1), 64'd1);
        cycle();
        chk("t5_idle", 64'(busy), 64'd0);

`ifdef IOB_PCIE_TX_ARB_TIMEOUT_EN
        // ACK never given, TIMEOUT=16
        do_reset();
        b_done0 = n_done0; b_beats = n_beats; b_err = n_err; b_tx = n_tx;
        ack_en = 1'b0;
        bus.req0_len = 32'd4;
        rem0 = 1;
        drive();
        wait_dones(n_done0 + n_done1 + 1, 100, "t6_timeout");
        cycle();
        chk("t6_err_pulses", 64'(n_err - b_err), 64'd1);
        chk("t6_err_cycle",  64'(err_cyc - ack_cyc), 64'd15);
        chk("t6_done_after", 64'(done_cyc - err_cyc), 64'd1);
        chk("t6_tx_cycles",  64'(n_tx - b_tx), 64'd16);
        chk("t6_done0",      64'(n_done0 - b_done0), 64'd1);
        chk("t6_beats",      64'(n_beats - b_beats), 64'd0);
        chk("t6_idle",       64'(busy), 64'd0);
        ack_en = 1'b1;
        chk("err_total", 64'(n_err), 64'd1);
`else
        chk("err_total", 64'(n_err), 64'd0);
`endif

        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
